// File: rtl/fp16_systolic_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : fp16_systolic_result_drain_if
// Purpose  : valid/ready stream of FP16 result words with row/col indices
// Revision : 1.0
// ============================================================================
interface fp16_systolic_result_drain_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_row;
  logic [IDX_W-1:0]  m_col;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, m_row, m_col, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_row, m_col, m_valid, m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/fp16_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : fp16_systolic_result_drain
// Purpose  : snapshots the 16x16 accumulator matrix and streams the NxN
//            sub-block row-major; optional DRAIN_ACC_CLEAR_EN enables the
//            one-cycle acc_clear_req pulse after each capture
// Revision : 1.0
// ============================================================================
module fp16_systolic_result_drain #(
  parameter int MAX_SIZE = 16,
  parameter int DATA_W   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [1:0]                           size_select,
  input  logic                                 abort,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_W-1:0]  acc_flat,
  fp16_systolic_result_drain_if.master         m_if,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 acc_clear_req
);

  localparam int IW = $clog2(MAX_SIZE);
  localparam int SW = $clog2(MAX_SIZE * MAX_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_snap [MAX_SIZE*MAX_SIZE];
  logic [IW-1:0]     r_n_last;
  logic [IW-1:0]     r_row;
  logic [IW-1:0]     r_col;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic              w_capture;
  logic              w_xfer;
  logic              w_col_wrap;
  logic [IW-1:0]     w_row_nxt;
  logic [IW-1:0]     w_col_nxt;
  logic              w_last_nxt;
  logic [SW-1:0]     w_rd_idx;
  logic [IW-1:0]     w_n_last_sel;

  assign w_capture = (r_state == S_IDLE) && start;
  assign w_xfer    = (r_state == S_STREAM) && m_if.m_ready;

  // size_select 11 aliases to 8x8
  always_comb begin
    w_n_last_sel = IW'(7);
    case (size_select)
      2'b00:   w_n_last_sel = IW'(3);
      2'b10:   w_n_last_sel = IW'(MAX_SIZE - 1);
      default: w_n_last_sel = IW'(7);
    endcase
  end

  always_comb begin
    w_col_wrap = (r_col == r_n_last);
    w_col_nxt  = w_col_wrap ? '0 : r_col + 1'b1;
    w_row_nxt  = w_col_wrap ? r_row + 1'b1 : r_row;
    w_last_nxt = (w_row_nxt == r_n_last) && (w_col_nxt == r_n_last);
    w_rd_idx   = SW'(w_row_nxt) * SW'(MAX_SIZE) + SW'(w_col_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // abort outranks the final transfer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer && r_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < MAX_SIZE * MAX_SIZE; k++) begin
        r_snap[k] <= acc_flat[k*DATA_W +: DATA_W];
      end
    end
  end

  // First beat comes straight from acc_flat since the snapshot lands this edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_last <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_data   <= '0;
      r_last   <= 1'b0;
    end else if (w_capture) begin
      r_n_last <= w_n_last_sel;
      r_row    <= '0;
      r_col    <= '0;
      r_data   <= acc_flat[DATA_W-1:0];
      r_last   <= 1'b0;
    end else if (w_xfer) begin
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_data   <= r_snap[w_rd_idx];
      r_last   <= w_last_nxt;
    end
  end

  assign m_if.m_valid = (r_state == S_STREAM);
  assign m_if.m_data  = r_data;
  assign m_if.m_row   = r_row;
  assign m_if.m_col   = r_col;
  assign m_if.m_last  = r_last;
  assign busy         = (r_state == S_STREAM);
  assign done         = (r_state == S_DONE);

`ifdef DRAIN_ACC_CLEAR_EN
  logic r_acc_clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_clear <= 1'b0;
    end else begin
      r_acc_clear <= w_capture;
    end
  end

  assign acc_clear_req = r_acc_clear;
`else
  assign acc_clear_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_systolic_result_drain
// Purpose  : self-checking bench for fp16_systolic_result_drain
// Revision : 1.0
// ============================================================================
module tb_fp16_systolic_result_drain;

  localparam int c_MAX = 16;
  localparam int c_DW  = 16;

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [1:0]                  size_select;
  logic                        abort;
  logic [c_MAX*c_MAX*c_DW-1:0] acc_flat;
  logic                        busy;
  logic                        done;
  logic                        acc_clear_req;

  fp16_systolic_result_drain_if #(.DATA_W(c_DW), .IDX_W(4)) m_if ();

  fp16_systolic_result_drain #(.MAX_SIZE(c_MAX), .DATA_W(c_DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .size_select   (size_select),
    .abort         (abort),
    .acc_flat      (acc_flat),
    .m_if          (m_if),
    .busy          (busy),
    .done          (done),
    .acc_clear_req (acc_clear_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
  } beat_t;

  typedef struct {
    logic [1:0] sel;
    int         mode;       // 0 ready always, 1 toggling, 2 random
    int         abort_at;   // beats completed before abort is raised, -1 none
    bit         ps_stream;
    bit         ps_done;
    bit         directed;
    int         exp_beats;
    int         exp_done;
  } vec_t;

  logic [15:0] mat [c_MAX][c_MAX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int dim_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 4;
      2'b01:   return 8;
      2'b10:   return 16;
      default: return 8;
    endcase
  endfunction

  task automatic scramble_acc();
    for (int k = 0; k < c_MAX * c_MAX; k++) acc_flat[k*c_DW +: c_DW] = 16'($urandom);
  endtask

  task automatic run_capture(input vec_t v);
    int    n, beats, dones, lasts, clr_cnt, clr_cyc, cyc, done_cyc;
    bit    stalled, finished, aborted, ps_used;
    beat_t q[$];
    beat_t b;
    logic [15:0] hold_d, last_d;
    logic [3:0]  hold_r, hold_c;
    logic        hold_l, rdy;

    n = dim_of(v.sel);
    for (int i = 0; i < c_MAX; i++)
      for (int j = 0; j < c_MAX; j++) begin
        mat[i][j] = v.directed ? 16'(16'h3C00 + i * 16 + j) : 16'($urandom);
        acc_flat[(i*c_MAX+j)*c_DW +: c_DW] = mat[i][j];
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        b.d = mat[i][j]; b.r = 4'(i); b.c = 4'(j);
        q.push_back(b);
      end

    beats = 0; dones = 0; lasts = 0; clr_cnt = 0; clr_cyc = -1; done_cyc = -1;
    stalled = 0; finished = 0; aborted = 0; ps_used = 0; last_d = '0;
    hold_d = '0; hold_r = '0; hold_c = '0; hold_l = 1'b0;
    start = 1'b1; size_select = v.sel; m_if.m_ready = 1'b0;
    if (acc_clear_req) clr_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_acc();
    cyc = 1;

    while (!finished && cyc < 3000) begin
      if (acc_clear_req) begin clr_cnt++; clr_cyc = cyc; end
      if (stalled)
        check("stall_hold", {m_if.m_valid, m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last},
              {1'b1, hold_d, hold_r, hold_c, hold_l});
      stalled = 0;
      if (aborted) begin
        check("abort_next", {m_if.m_valid, busy, done}, 3'b000);
        finished = 1;
      end else if (done) begin
        dones++; done_cyc = cyc;
        m_if.m_ready = 1'b0;
        if (v.ps_done) start = 1'b1;
        finished = 1;
      end else if (m_if.m_valid) begin
        if (v.mode == 0)      rdy = 1'b1;
        else if (v.mode == 1) rdy = cyc[0];
        else                  rdy = 1'($urandom_range(0, 1));
        if (v.abort_at >= 0 && beats == v.abort_at) begin
          abort = 1'b1; rdy = 1'b1; aborted = 1;
        end
        if (v.ps_stream && !ps_used && beats == 3) begin
          start = 1'b1; size_select = 2'b10; ps_used = 1;
        end
        m_if.m_ready = rdy;
        if (busy !== 1'b1) check("busy_stream", busy, 1'b1);
        if (rdy) begin
          if (q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            b = q.pop_front();
            check("beat", {m_if.m_data, m_if.m_row, m_if.m_col, m_if.m_last},
                  {b.d, b.r, b.c, (int'(b.r) == n - 1 && int'(b.c) == n - 1)});
            if (v.mode == 0) check("beat_cycle", cyc, beats + 1);
          end
          if (m_if.m_last) lasts++;
          last_d = m_if.m_data;
          beats++;
        end else begin
          stalled = 1;
          hold_d = m_if.m_data; hold_r = m_if.m_row; hold_c = m_if.m_col; hold_l = m_if.m_last;
        end
      end else begin
        check("valid_gap", m_if.m_valid, 1'b1);
      end
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      scramble_acc();
      cyc++;
    end

    check("finished", finished, 1'b1);
    check("post_idle", {m_if.m_valid, busy, done}, 3'b000);
    check("beat_count", beats, v.exp_beats);
    check("done_count", dones, v.exp_done);
    check("last_count", lasts, v.exp_done);
    if (v.mode == 0 && v.exp_done == 1) check("done_cycle", done_cyc, n * n + 1);
    if (v.directed && v.exp_done == 1) check("last_data", last_d, 16'h3C33);
`ifdef DRAIN_ACC_CLEAR_EN
    check("acc_clear", {32'(clr_cnt), 32'(clr_cyc)}, {32'd1, 32'd1});
`else
    check("acc_clear", clr_cnt, 0);
`endif
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; size_select = 2'b00;
    acc_flat = '0; m_if.m_ready = 1'b0;

    vecs[0] = '{2'b00, 0, -1, 1'b0, 1'b0, 1'b1, 16,  1};
    vecs[1] = '{2'b10, 1, -1, 1'b1, 1'b0, 1'b0, 256, 1};
    vecs[2] = '{2'b01, 0, -1, 1'b0, 1'b0, 1'b0, 64,  1};
    vecs[3] = '{2'b11, 2, -1, 1'b0, 1'b1, 1'b0, 64,  1};
    vecs[4] = '{2'b11, 0, -1, 1'b0, 1'b0, 1'b0, 64,  1};
    vecs[5] = '{2'b01, 0,  5, 1'b0, 1'b0, 1'b0, 6,   0};
    vecs[6] = '{2'b00, 2, -1, 1'b0, 1'b0, 1'b0, 16,  1};
    vecs[7] = '{2'b10, 0, -1, 1'b0, 1'b0, 1'b0, 256, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {m_if.m_valid, m_if.m_last, busy, done, acc_clear_req}, 5'b0);
    check("reset_data", m_if.m_data, 16'h0);
    check("reset_idx", {m_if.m_row, m_if.m_col}, 8'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) run_capture(vecs[t]);

    for (int t = 0; t < 6; t++) begin
      rv.sel = 2'($urandom_range(0, 3));
      rv.mode = $urandom_range(0, 2);
      rv.abort_at = -1; rv.ps_stream = 1'b0; rv.ps_done = 1'b0; rv.directed = 1'b0;
      rv.exp_beats = dim_of(rv.sel) * dim_of(rv.sel);
      rv.exp_done = 1;
      run_capture(rv);
    end

    // reset in the middle of a 16x16 stream
    scramble_acc();
    start = 1'b1; size_select = 2'b10;
    @(posedge clk); #1;
    start = 1'b0; m_if.m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_valid", m_if.m_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ctrl", {m_if.m_valid, m_if.m_last, busy, done, acc_clear_req}, 5'b0);
    check("midrst_data", {m_if.m_data, m_if.m_row, m_if.m_col}, 24'h0);
    rst_n = 1'b1; m_if.m_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_nodone", {m_if.m_valid, busy, done}, 3'b000);
    run_capture(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
